// File: rtl/ram_bank_fifo_ctrl.sv
// FIFO controller in front of a 1-cycle-read RAM bank, feeding a 2-entry output buffer.
// Define RAM_BANK_FIFO_STATUS_EN to add the level / almost_full status ports.
module ram_bank_fifo_ctrl #(
  parameter int ADDR_BIT   = 3,
  parameter int DATA_BIT   = 16,
  parameter int MEM_HEIGHT = 8,
  parameter int AF_THRESH  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_BIT-1:0] in_data,
  output logic                bank_en,
  output logic                bank_we,
  output logic [ADDR_BIT-1:0] bank_addr_w,
  output logic [DATA_BIT-1:0] bank_d_w,
  output logic                bank_re,
  output logic [ADDR_BIT-1:0] bank_addr_r,
  input  logic [DATA_BIT-1:0] bank_d_r,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_BIT-1:0] out_data
`ifdef RAM_BANK_FIFO_STATUS_EN
  ,
  output logic [ADDR_BIT+1:0] level,
  output logic                almost_full
`endif
);

  localparam logic [ADDR_BIT-1:0] PTR_LAST = ADDR_BIT'(MEM_HEIGHT - 1);
  localparam logic [ADDR_BIT:0]   CNT_FULL = (ADDR_BIT+1)'(MEM_HEIGHT);

  logic [ADDR_BIT-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_BIT:0]   r_ram_cnt, w_ram_cnt_nxt;
  logic                r_rd_pend;
  logic [1:0]          r_ob_cnt, w_ob_rem, w_ob_cnt_nxt;
  logic [2:0]          w_ob_claim;
  logic [DATA_BIT-1:0] r_ob0, r_ob1;
  logic                w_push, w_pop, w_re;

  // Pointers wrap at the bank depth, which need not be a power of two.
  function automatic logic [ADDR_BIT-1:0] ptr_inc(input logic [ADDR_BIT-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (r_ram_cnt != CNT_FULL);
  assign w_push    = in_valid & in_ready;
  assign out_valid = (r_ob_cnt != 2'd0);
  assign w_pop     = out_valid & out_ready;

  // A read may only be issued if its word is guaranteed a buffer slot on arrival.
  assign w_ob_claim    = {1'b0, r_ob_cnt} + {2'b00, r_rd_pend} - {2'b00, w_pop};
  assign w_re          = (r_ram_cnt != '0) && (w_ob_claim < 3'd2);
  assign w_ob_rem      = r_ob_cnt - {1'b0, w_pop};
  assign w_ob_cnt_nxt  = w_ob_rem + {1'b0, r_rd_pend};
  assign w_ram_cnt_nxt = r_ram_cnt + {{ADDR_BIT{1'b0}}, w_push} - {{ADDR_BIT{1'b0}}, w_re};

  assign bank_we     = w_push;
  assign bank_re     = w_re;
  assign bank_en     = w_push | w_re;
  assign bank_addr_w = r_wr_ptr;
  assign bank_addr_r = r_rd_ptr;
  assign bank_d_w    = in_data;
  assign out_data    = r_ob0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ram_cnt <= '0;
      r_rd_pend <= 1'b0;
      r_ob_cnt  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_re)   r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_ram_cnt <= w_ram_cnt_nxt;
      r_rd_pend <= w_re;
      r_ob_cnt  <= w_ob_cnt_nxt;
    end
  end

  // Returning bank data lands in the first slot left free after this cycle's pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ob0 <= '0;
      r_ob1 <= '0;
    end else begin
      if (r_rd_pend && (w_ob_rem == 2'd0)) r_ob0 <= bank_d_r;
      else if (w_pop)                      r_ob0 <= r_ob1;
      if (r_rd_pend && (w_ob_rem == 2'd1)) r_ob1 <= bank_d_r;
    end
  end

`ifdef RAM_BANK_FIFO_STATUS_EN
  logic [ADDR_BIT+1:0] r_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_level <= '0;
    else     r_level <= {1'b0, w_ram_cnt_nxt} + {{(ADDR_BIT+1){1'b0}}, w_re}
                        + {{ADDR_BIT{1'b0}}, w_ob_cnt_nxt};
  end

  assign level       = r_level;
  assign almost_full = (r_level >= (ADDR_BIT+2)'(AF_THRESH));
`endif

endmodule
